// File: rtl/sonic_pkg.sv
// Shared FSM encoding, us->cm reciprocal and tick-divider helper for the ping scheduler.
// No logic of its own; no latency or backpressure.
package sonic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_TRIGGER,
        ST_WAIT_ECHO,
        ST_MEASURE,
        ST_WRITE,
        ST_GAP
    } state_t;

    // 65536/58 rounded: (us * US_PER_CM) >> 16 approximates us/58.
    localparam int US_PER_CM = 1130;

    function automatic int tick_div(input int clk_hz);
        int d;
        d = clk_hz / 1_000_000;
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/sonic_tick_gen.sv
// Free-running 1 us strobe: one-cycle pulse every CLK_HZ/1e6 clocks, registered output.
// Latency: first pulse one divider period after reset; no backpressure.
module sonic_tick_gen
    import sonic_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    localparam int               DIV   = tick_div(CLK_HZ);
    localparam int               DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] LAST  = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] r_cnt;
    logic             r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_cnt == LAST);
            r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/sonic_ping_scheduler.sv
// Round-robin HC-SR04 ranging over N_SENS channels; optional o_res_cm when SONIC_PING_CM_EN is defined.
// Latency: one ping = trigger + echo + GAP_US; result held on valid until ready, next ping waits for the handshake.
module sonic_ping_scheduler
    import sonic_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int N_SENS     = 4,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000,
    parameter int GAP_US     = 60000,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_en,
    input  logic [N_SENS-1:0]         i_ch_mask,
    input  logic [N_SENS-1:0]         i_echo,
    output logic [N_SENS-1:0]         o_trig,
    output logic                      o_busy,
    output logic                      o_res_valid,
    input  logic                      i_res_ready,
    output logic [$clog2(N_SENS)-1:0] o_res_ch,
    output logic [CNT_W-1:0]          o_res_us,
    output logic                      o_res_timeout
`ifdef SONIC_PING_CM_EN
    ,
    output logic [CNT_W-1:0]          o_res_cm
`endif
);

    localparam int               CH_W      = $clog2(N_SENS);
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_US - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_US - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_US - 1);
    localparam logic [CNT_W-1:0] TO_VAL    = CNT_W'(TIMEOUT_US);

`ifdef SONIC_PING_CM_EN
    localparam int PROD_W = CNT_W + 11;

    function automatic logic [CNT_W-1:0] f_cm(input logic [CNT_W-1:0] us);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(us) * PROD_W'(US_PER_CM);
        prod = prod >> 16;
        return prod[CNT_W-1:0];
    endfunction

    logic [CNT_W-1:0] r_res_cm;
`endif

    state_t             r_state;
    logic [CH_W-1:0]    r_ptr;
    logic [CH_W-1:0]    r_ch;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_SENS-1:0]  r_trig;
    logic               r_busy;
    logic               r_res_valid;
    logic [CH_W-1:0]    r_res_ch;
    logic [CNT_W-1:0]   r_res_us;
    logic               r_res_to;
    logic [N_SENS-1:0]  r_echo_s1;
    logic [N_SENS-1:0]  r_echo_s2;
    logic [N_SENS-1:0]  r_echo_d;

    logic               w_tick;
    logic               w_echo_rise;
    logic               w_echo_fall;
    logic               w_sel_found;
    logic [CH_W-1:0]    w_sel_ch;
    logic [CH_W-1:0]    w_cand;

    sonic_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_echo_s1 <= '0;
            r_echo_s2 <= '0;
            r_echo_d  <= '0;
        end else begin
            r_echo_s1 <= i_echo;
            r_echo_s2 <= r_echo_s1;
            r_echo_d  <= r_echo_s2;
        end
    end

    assign w_echo_rise =  r_echo_s2[r_ch] & ~r_echo_d[r_ch];
    assign w_echo_fall = ~r_echo_s2[r_ch] &  r_echo_d[r_ch];

    // First enabled channel after the pointer, wrapping; the pointer itself is tried last.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_ch    = r_ptr;
        w_cand      = '0;
        for (int k = 1; k <= N_SENS; k++) begin
            w_cand = CH_W'((int'(r_ptr) + k) % N_SENS);
            if (!w_sel_found && i_ch_mask[w_cand]) begin
                w_sel_found = 1'b1;
                w_sel_ch    = w_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= CH_W'(N_SENS - 1);
            r_ch        <= '0;
            r_cnt       <= '0;
            r_trig      <= '0;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_ch    <= '0;
            r_res_us    <= '0;
            r_res_to    <= 1'b0;
`ifdef SONIC_PING_CM_EN
            r_res_cm    <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_en && (|i_ch_mask)) begin
                        r_state <= ST_SELECT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SELECT: begin
                    if (w_sel_found) begin
                        r_ptr   <= w_sel_ch;
                        r_ch    <= w_sel_ch;
                        r_trig  <= N_SENS'(1) << w_sel_ch;
                        r_cnt   <= '0;
                        r_state <= ST_TRIGGER;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_TRIGGER: begin
                    if (w_tick) begin
                        if (r_cnt >= TRIG_LAST) begin
                            r_trig  <= '0;
                            r_cnt   <= '0;
                            r_state <= ST_WAIT_ECHO;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_WAIT_ECHO: begin
                    // A level already high on entry never produces a rise here.
                    if (w_echo_rise) begin
                        r_cnt   <= '0;
                        r_state <= ST_MEASURE;
                    end else if (w_tick) begin
                        if (r_cnt >= TO_LAST) begin
                            r_res_ch    <= r_ch;
                            r_res_us    <= TO_VAL;
                            r_res_to    <= 1'b1;
                            r_res_valid <= 1'b1;
`ifdef SONIC_PING_CM_EN
                            r_res_cm    <= '0;
`endif
                            r_state     <= ST_WRITE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_MEASURE: begin
                    if (w_echo_fall) begin
                        r_res_ch    <= r_ch;
                        r_res_us    <= r_cnt;
                        r_res_to    <= 1'b0;
                        r_res_valid <= 1'b1;
`ifdef SONIC_PING_CM_EN
                        r_res_cm    <= f_cm(r_cnt);
`endif
                        r_state     <= ST_WRITE;
                    end else if (w_tick) begin
                        if (r_cnt >= TO_LAST) begin
                            r_res_ch    <= r_ch;
                            r_res_us    <= TO_VAL;
                            r_res_to    <= 1'b1;
                            r_res_valid <= 1'b1;
`ifdef SONIC_PING_CM_EN
                            r_res_cm    <= '0;
`endif
                            r_state     <= ST_WRITE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        if (r_cnt >= GAP_LAST) begin
                            if (i_en) begin
                                r_state <= ST_SELECT;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_trig  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_trig        = r_trig;
    assign o_busy        = r_busy;
    assign o_res_valid   = r_res_valid;
    assign o_res_ch      = r_res_ch;
    assign o_res_us      = r_res_us;
    assign o_res_timeout = r_res_to;
`ifdef SONIC_PING_CM_EN
    assign o_res_cm      = r_res_cm;
`endif

endmodule

// File: tb/tb_sonic_ping_scheduler.sv
// Bench for sonic_ping_scheduler: directed vector table, reset corner cases, randomized pings vs. a round-robin model.
module tb_sonic_ping_scheduler;

    localparam int CLK_HZ     = 10_000_000;
    localparam int N_SENS     = 4;
    localparam int TRIG_US    = 10;
    localparam int TIMEOUT_US = 500;
    localparam int GAP_US     = 100;
    localparam int CNT_W      = 16;
    localparam int DIV        = CLK_HZ / 1_000_000;
    localparam int LIMIT      = 8000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [3:0]        ch_mask = 4'b0;
    logic [3:0]        echo;
    logic [3:0]        trig;
    logic              busy;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [1:0]        res_ch;
    logic [CNT_W-1:0]  res_us;
    logic              res_to;
`ifdef SONIC_PING_CM_EN
    logic [CNT_W-1:0]  res_cm;
`endif

    logic [3:0] pulse;
    logic [3:0] stuck = 4'b0;
    int         cfg_dly = 0;
    int         cfg_wid = 0;
    int         total = 0;
    int         bad = 0;

    assign echo = pulse | stuck;

    always #5 clk = ~clk;

    sonic_ping_scheduler #(
        .CLK_HZ(CLK_HZ), .N_SENS(N_SENS), .TRIG_US(TRIG_US),
        .TIMEOUT_US(TIMEOUT_US), .GAP_US(GAP_US), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_en(en),
        .i_ch_mask(ch_mask),
        .i_echo(echo),
        .o_trig(trig),
        .o_busy(busy),
        .o_res_valid(res_valid),
        .i_res_ready(res_ready),
        .o_res_ch(res_ch),
        .o_res_us(res_us),
        .o_res_timeout(res_to)
`ifdef SONIC_PING_CM_EN
        ,
        .o_res_cm(res_cm)
`endif
    );

    typedef struct {
        logic [3:0] mask;
        int         dly;
        int         wid;
        logic [3:0] stuck;
        int         hold;
        int         exp_ch;
        int         exp_to;
        int         exp_us;
    } vec_t;

    vec_t tbl[8];

    function automatic int onehot_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int next_ch(input int last, input logic [3:0] m);
        for (int k = 1; k <= 4; k++) if (m[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Echo emulator: after a trigger falls, waits cfg_dly us then drives a cfg_wid us pulse.
    initial begin
        logic [3:0] prev;
        int rch, dly, wid;
        bit active;
        prev = 4'b0; pulse = 4'b0; rch = 0; dly = 0; wid = 0; active = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0;
                pulse  = 4'b0;
            end else if (prev != 4'b0 && trig == 4'b0) begin
                active = 1'b1;
                rch    = onehot_idx(prev);
                dly    = cfg_dly * DIV;
                wid    = cfg_wid * DIV;
            end else if (active) begin
                if (dly > 0) dly--;
                else if (wid > 0) begin
                    pulse[rch] = 1'b1;
                    wid--;
                end else begin
                    pulse  = 4'b0;
                    active = 1'b0;
                end
            end
            prev = trig;
        end
    end

    task automatic wait_trig_rise(output int ch, output int cyc);
        cyc = 0;
        while (trig == 4'b0 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check("trig_seen", int'(trig != 4'b0), 1);
        check("trig_onehot", $countones(trig), 1);
        ch = onehot_idx(trig);
    endtask

    task automatic trig_width(output int w);
        w = 0;
        while (trig != 4'b0 && w < 1000) begin
            w++;
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(output int lat, output int ch, output int us, output int to, output int cm);
        lat = 0;
        while (!res_valid && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        check("valid_seen", int'(res_valid), 1);
        ch = int'(res_ch);
        us = int'(res_us);
        to = int'(res_to);
`ifdef SONIC_PING_CM_EN
        cm = int'(res_cm);
`else
        cm = 0;
`endif
    endtask

    task automatic finish_handshake(input int hold, output int hold_bad);
        logic [1:0]       c0;
        logic [CNT_W-1:0] u0;
        logic             t0;
        c0 = res_ch; u0 = res_us; t0 = res_to;
        hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!res_valid || res_ch != c0 || res_us != u0 || res_to != t0 || trig != 4'b0)
                hold_bad++;
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("valid_drop", int'(res_valid), 0);
    endtask

    task automatic check_cm(input string name, input int us, input int to, input int cm);
`ifdef SONIC_PING_CM_EN
        if (to != 0) check(name, cm, 0);
        else         check(name, cm, (us * 1130) >> 16);
`endif
    endtask

    // Reset asserted between clock edges: outputs must clear before the next edge.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_trig"}, int'(trig), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_valid"}, int'(res_valid), 0);
        check({tag, "_res_ch"}, int'(res_ch), 0);
        check({tag, "_res_us"}, int'(res_us), 0);
        check({tag, "_res_to"}, int'(res_to), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply_vec(input int i);
        ch_mask = tbl[i].mask;
        cfg_dly = tbl[i].dly;
        cfg_wid = tbl[i].wid;
        stuck   = tbl[i].stuck;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, want completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int ch, cyc, w, lat, rch, rus, rto, rcm, hb, m_last, cur_wid, hold, exp_ch;
        logic [3:0] cur_mask;

        tbl[0] = '{4'b0001, 20, 290, 4'b0000, 0,  0, 0, 290};
        tbl[1] = '{4'b0010,  0,   0, 4'b0000, 0,  1, 1, 500};
        tbl[2] = '{4'b1000,  5,  30, 4'b0000, 0,  3, 0,  30};
        tbl[3] = '{4'b1011,  5,  30, 4'b0000, 0,  0, 0,  30};
        tbl[4] = '{4'b1011,  8,  40, 4'b0000, 0,  1, 0,  40};
        tbl[5] = '{4'b1011,  0,   0, 4'b1000, 0,  3, 1, 500};
        tbl[6] = '{4'b1011,  3,  25, 4'b0000, 0,  0, 0,  25};
        tbl[7] = '{4'b1011,  6,  45, 4'b0000, 50, 1, 0,  45};

        repeat (3) @(negedge clk);
        check("rst_trig", int'(trig), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(res_valid), 0);
        check("rst_ch", int'(res_ch), 0);
        check("rst_us", int'(res_us), 0);
        check("rst_to", int'(res_to), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        apply_vec(0);
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_trig_rise(ch, cyc);
            if (i > 0) check_rng($sformatf("v%0d_gap_to_trig", i), cyc, 985, 1010);
            check($sformatf("v%0d_trig_ch", i), ch, tbl[i].exp_ch);
            trig_width(w);
            check_rng($sformatf("v%0d_trig_width", i), w, (TRIG_US - 1) * DIV + 1, TRIG_US * DIV);
            wait_valid(lat, rch, rus, rto, rcm);
            if (tbl[i].exp_to != 0) check_rng($sformatf("v%0d_timeout_lat", i), lat, 4985, 5010);
            check($sformatf("v%0d_res_ch", i), rch, tbl[i].exp_ch);
            check($sformatf("v%0d_res_to", i), rto, tbl[i].exp_to);
            if (tbl[i].exp_to != 0) check($sformatf("v%0d_res_us", i), rus, tbl[i].exp_us);
            else check_rng($sformatf("v%0d_res_us", i), rus, tbl[i].exp_us - 1, tbl[i].exp_us + 1);
            check_cm($sformatf("v%0d_res_cm", i), rus, rto, rcm);
            if (i < 7) apply_vec(i + 1);
            else en = 1'b0;
            finish_handshake(tbl[i].hold, hb);
            if (tbl[i].hold > 0) check($sformatf("v%0d_hold_stable", i), hb, 0);
        end
        cyc = 0;
        while (busy && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check_rng("en_low_busy_drop", cyc, 985, 1010);

        // Reset mid-MEASURE, mid-TRIGGER and mid-WRITE; pointer restarts at the lowest channel.
        ch_mask = 4'b0110; cfg_dly = 5; cfg_wid = 200; stuck = 4'b0;
        en = 1'b1;
        wait_trig_rise(ch, cyc);
        check("pre_rst_ch", ch, 2);
        trig_width(w);
        repeat (5 * DIV + 300) @(negedge clk);
        check("busy_in_measure", int'(busy), 1);
        pulse_reset("rst_measure");
        wait_trig_rise(ch, cyc);
        check("post_rst_ch", ch, 1);
        repeat (20) @(negedge clk);
        pulse_reset("rst_trigger");
        wait_trig_rise(ch, cyc);
        check("post_rst2_ch", ch, 1);
        trig_width(w);
        wait_valid(lat, rch, rus, rto, rcm);
        check("rst_seq_res_ch", rch, 1);
        check_rng("rst_seq_res_us", rus, 199, 201);
        repeat (10) @(negedge clk);
        en = 1'b0;
        pulse_reset("rst_write");
        repeat (5) @(negedge clk);

        // Randomized pings against the round-robin rule.
        m_last   = N_SENS - 1;
        cur_mask = 4'($urandom_range(1, 15));
        cur_wid  = $urandom_range(5, 120);
        ch_mask  = cur_mask;
        cfg_dly  = $urandom_range(2, 30);
        cfg_wid  = cur_wid;
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_ch = next_ch(m_last, cur_mask);
            wait_trig_rise(ch, cyc);
            check($sformatf("r%0d_trig_ch", k), ch, exp_ch);
            trig_width(w);
            check_rng($sformatf("r%0d_trig_width", k), w, (TRIG_US - 1) * DIV + 1, TRIG_US * DIV);
            wait_valid(lat, rch, rus, rto, rcm);
            check($sformatf("r%0d_res_ch", k), rch, exp_ch);
            check($sformatf("r%0d_res_to", k), rto, 0);
            check_rng($sformatf("r%0d_res_us", k), rus, cur_wid - 1, cur_wid + 1);
            check_cm($sformatf("r%0d_res_cm", k), rus, rto, rcm);
            m_last   = exp_ch;
            cur_mask = 4'($urandom_range(1, 15));
            cur_wid  = $urandom_range(5, 120);
            ch_mask  = cur_mask;
            cfg_dly  = $urandom_range(2, 30);
            cfg_wid  = cur_wid;
            hold     = $urandom_range(0, 5);
            finish_handshake(hold, hb);
            if (hold > 0) check($sformatf("r%0d_hold_stable", k), hb, 0);
        end
        en = 1'b0;
        cyc = 0;
        while (busy && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check("final_idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
